eq_setting_sweep_ctrl: RTL and testbench
========================================

Name: eq_setting_sweep_ctrl

Overview:
Link-training controller for the receive equalizer path. On start it steps the equalizer through NUM_SETTINGS discrete settings. For each setting it waits for the filter to settle, then counts decision errors against the PRBS reference over a fixed window of valid samples. It then applies the setting with the fewest errors and holds it until restarted. It sits between the training/PRBS checker logic and the equalizer model, and drives the equalizer's setting select.

Parameters:
NUM_SETTINGS, 8, number of equalizer settings swept (indices 0..NUM_SETTINGS-1)
SET_W, 3, width of eq_setting; must satisfy 2**SET_W >= NUM_SETTINGS
SETTLE_CYCLES, 16, clock cycles ignored after every setting change (>=1)
WINDOW_LEN, 1024, number of valid samples counted per setting (>=1)
ERR_W, 11, error-counter width; must hold WINDOW_LEN without overflow
ERR_LIMIT, 0, fail asserts if the best error count exceeds this value

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a sweep; ignored while busy
abort  in  1  synchronous abort; returns to IDLE from any state
sample_valid  in  1  sample_bit/expected_bit are valid this cycle
sample_bit  in  1  equalizer decision output
expected_bit  in  1  aligned PRBS reference bit
eq_setting  out  SET_W  setting index driven to the equalizer
busy  out  1  high from the cycle after start until LOCKED or abort
done  out  1  one-cycle pulse on entry to LOCKED
locked  out  1  high while in LOCKED
fail  out  1  valid while locked; best_err > ERR_LIMIT
best_err  out  ERR_W  error count of the chosen setting; valid while locked

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0: eq_setting=0, busy=0, done=0, locked=0, fail=0, best_err=0
  - state=IDLE; internal counters 0; internal best register = all ones
- States: IDLE, SETTLE, MEASURE, EVAL, APPLY, LOCKED.
- IDLE or LOCKED, start=1:
  - eq_setting<=0; internal best<=all ones; best_idx<=0
  - clear locked, fail, best_err; busy<=1; go to SETTLE
- SETTLE: spend exactly SETTLE_CYCLES cycles; sample inputs ignored. Then go to MEASURE with err_cnt=0 and sample_cnt=0.
- MEASURE:
  - on each cycle with sample_valid=1: sample_cnt++; err_cnt += (sample_bit != expected_bit)
  - cycles with sample_valid=0 do not advance the window
  - the cycle in which sample_cnt reaches WINDOW_LEN includes that sample; next state is EVAL
- EVAL (1 cycle):
  - if err_cnt < internal best (strict), best<=err_cnt and best_idx<=eq_setting; ties keep the lower index
  - if eq_setting == NUM_SETTINGS-1, go to APPLY
  - else eq_setting++ and go to SETTLE
- APPLY (1 cycle): eq_setting<=best_idx; best_err<=best; go to LOCKED.
- LOCKED:
  - locked=1, busy=0, done=1 only in the first cycle
  - fail = (best_err > ERR_LIMIT)
  - eq_setting holds until start, abort or reset
- Latency: with sample_valid held high, done is high in cycle NUM_SETTINGS*(SETTLE_CYCLES+WINDOW_LEN+1)+2 after the start edge.
- start while busy: ignored; no restart, no state disturbance.
- abort=1 in any state: next cycle IDLE; eq_setting=0, busy=0, locked=0, done=0, fail=0. abort has priority over start in the same cycle.
- rst_n deasserted mid-sweep: immediate return to the reset values; no partial result retained.
- err_cnt never exceeds WINDOW_LEN, so there is no saturation logic. ERR_W < clog2(WINDOW_LEN+1) is an elaboration error.
- All errors (err_cnt = WINDOW_LEN on every setting): best_idx=0, best_err=WINDOW_LEN, fail=1 when ERR_LIMIT < WINDOW_LEN.

Decomposition:
- Package eq_ctrl_pkg contains:
  - state enum type eq_sweep_state_t
  - default parameter constants
  - elaboration-time check function for ERR_W vs WINDOW_LEN
- Sub-module eq_err_window_counter:
  - inputs: clear, enable, sample_valid, sample_bit, expected_bit
  - outputs: err_cnt, window_done
  - holds the per-window sample and error counters
  - the controller FSM instantiates it once

Test Plan:
- Params NUM_SETTINGS=4, SETTLE_CYCLES=2, WINDOW_LEN=8, sample_valid=1; per-setting error counts 5,1,3,1 -> eq_setting=1, best_err=1, fail=1, done pulse in cycle 46 after start.
- Same params with errors 0 on setting 3 only and ERR_LIMIT=0 -> eq_setting=3, best_err=0, fail=0, locked=1.
- sample_valid toggling 1/0 every cycle during MEASURE -> each window spans 16 cycles; done in cycle 4*(2+16+1)+2 = 78; counts unchanged.
- abort asserted in MEASURE of setting 2 -> next cycle IDLE, eq_setting=0, busy=0; later start produces a full fresh sweep with correct result.
- start pulsed mid-sweep, then again while LOCKED -> first ignored (timing unchanged); second restarts at eq_setting=0 with locked cleared.
- rst_n asserted low in SETTLE of setting 1 -> all outputs 0 immediately (asynchronously), state IDLE.

Source files
------------

// File: rtl/eq_setting_sweep_ctrl_pkg.sv
// Shared types, default parameters and elaboration checks for the
// equalizer setting sweep controller.
package eq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_EVAL,
        ST_APPLY,
        ST_LOCKED
    } eq_sweep_state_t;

    localparam int unsigned DEF_NUM_SETTINGS  = 8;
    localparam int unsigned DEF_SET_W         = 3;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;
    localparam int unsigned DEF_WINDOW_LEN    = 1024;
    localparam int unsigned DEF_ERR_W         = 11;
    localparam int unsigned DEF_ERR_LIMIT     = 0;

    // True when an err_w-bit counter can hold window_len without wrapping.
    function automatic bit err_w_fits(input int unsigned err_w, input int unsigned window_len);
        return (longint'(1) << err_w) > longint'(window_len);
    endfunction

endpackage

// File: rtl/eq_setting_sweep_ctrl_if.sv
// Control/status and sample bundle between training logic and the sweep
// controller; master = training side, slave = controller.
interface eq_setting_sweep_ctrl_if
    import eq_ctrl_pkg::*;
#(
    parameter int unsigned SET_W = DEF_SET_W,
    parameter int unsigned ERR_W = DEF_ERR_W
);
    logic             start;
    logic             abort;
    logic             sample_valid;
    logic             sample_bit;
    logic             expected_bit;
    logic [SET_W-1:0] eq_setting;
    logic             busy;
    logic             done;
    logic             locked;
    logic             fail;
    logic [ERR_W-1:0] best_err;

    modport master (
        output start, abort, sample_valid, sample_bit, expected_bit,
        input  eq_setting, busy, done, locked, fail, best_err
    );

    modport slave (
        input  start, abort, sample_valid, sample_bit, expected_bit,
        output eq_setting, busy, done, locked, fail, best_err
    );
endinterface

// File: rtl/eq_setting_sweep_ctrl_err_window_counter.sv
// Per-window sample and decision-error counters; window_done flags the
// valid sample that completes the window.
module eq_err_window_counter
    import eq_ctrl_pkg::*;
#(
    parameter int unsigned WINDOW_LEN = DEF_WINDOW_LEN,
    parameter int unsigned ERR_W      = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic             sample_bit,
    input  logic             expected_bit,
    output logic [ERR_W-1:0] err_cnt,
    output logic             window_done
);

    // Samples still owed to the window after the current one.
    logic [ERR_W-1:0] remaining;
    logic             take;

    assign take        = enable & sample_valid;
    assign window_done = take & (remaining == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            err_cnt   <= '0;
        end else if (clear) begin
            remaining <= ERR_W'(WINDOW_LEN - 1);
            err_cnt   <= '0;
        end else if (take) begin
            remaining <= remaining - ERR_W'(1);
            err_cnt   <= err_cnt + ERR_W'(sample_bit ^ expected_bit);
        end
    end

endmodule

// File: rtl/eq_setting_sweep_ctrl.sv
// Equalizer link-training sweep: measures the error count of every setting
// and locks onto the lowest one (lowest index wins ties).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_SETTLE  | filter settling after a setting change, samples ignored
// ST_MEASURE | counting errors over WINDOW_LEN valid samples
// ST_EVAL    | compare against best so far, advance to next setting
// ST_APPLY   | drive best setting, publish best_err
// ST_LOCKED  | holding best setting until start/abort/reset
module eq_setting_sweep_ctrl
    import eq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SETTINGS  = DEF_NUM_SETTINGS,
    parameter int unsigned SET_W         = DEF_SET_W,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned WINDOW_LEN    = DEF_WINDOW_LEN,
    parameter int unsigned ERR_W         = DEF_ERR_W,
    parameter int unsigned ERR_LIMIT     = DEF_ERR_LIMIT
) (
    input logic                  clk,
    input logic                  rst_n,
    eq_setting_sweep_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    if (!err_w_fits(ERR_W, WINDOW_LEN)) begin : g_err_w_chk
        $error("ERR_W cannot hold WINDOW_LEN");
    end
    if ((longint'(1) << SET_W) < longint'(NUM_SETTINGS)) begin : g_set_w_chk
        $error("SET_W cannot index NUM_SETTINGS");
    end

    eq_sweep_state_t  state;
    logic [CNT_W-1:0] settle_cnt;
    logic [ERR_W-1:0] best_q;
    logic [SET_W-1:0] best_idx;
    logic [ERR_W-1:0] err_cnt;
    logic             window_done;

    eq_err_window_counter #(
        .WINDOW_LEN (WINDOW_LEN),
        .ERR_W      (ERR_W)
    ) u_err_window (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (state == ST_SETTLE),
        .enable       (state == ST_MEASURE),
        .sample_valid (bus.sample_valid),
        .sample_bit   (bus.sample_bit),
        .expected_bit (bus.expected_bit),
        .err_cnt      (err_cnt),
        .window_done  (window_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            best_q         <= '1;
            best_idx       <= '0;
            bus.eq_setting <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.locked     <= 1'b0;
            bus.fail       <= 1'b0;
            bus.best_err   <= '0;
        end else if (bus.abort) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            bus.eq_setting <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.locked     <= 1'b0;
            bus.fail       <= 1'b0;
            bus.best_err   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE, ST_LOCKED: begin
                    if (bus.start) begin
                        bus.eq_setting <= '0;
                        best_q         <= '1;
                        best_idx       <= '0;
                        bus.locked     <= 1'b0;
                        bus.fail       <= 1'b0;
                        bus.best_err   <= '0;
                        bus.busy       <= 1'b1;
                        settle_cnt     <= CNT_W'(SETTLE_CYCLES - 1);
                        state          <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) state <= ST_MEASURE;
                    else                  settle_cnt <= settle_cnt - CNT_W'(1);
                end
                ST_MEASURE: begin
                    if (window_done) state <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (err_cnt < best_q) begin
                        best_q   <= err_cnt;
                        best_idx <= bus.eq_setting;
                    end
                    if (bus.eq_setting == SET_W'(NUM_SETTINGS - 1)) begin
                        state <= ST_APPLY;
                    end else begin
                        bus.eq_setting <= bus.eq_setting + SET_W'(1);
                        settle_cnt     <= CNT_W'(SETTLE_CYCLES - 1);
                        state          <= ST_SETTLE;
                    end
                end
                ST_APPLY: begin
                    bus.eq_setting <= best_idx;
                    bus.best_err   <= best_q;
                    bus.fail       <= (32'(best_q) > ERR_LIMIT);
                    bus.busy       <= 1'b0;
                    bus.locked     <= 1'b1;
                    bus.done       <= 1'b1;
                    state          <= ST_LOCKED;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_setting_sweep_ctrl.sv
// Bench for eq_setting_sweep_ctrl: a table of sweeps plus random sweeps
// against an argmin reference, and abort/restart/reset corner sequences.
module tb_eq_setting_sweep_ctrl;
    import eq_ctrl_pkg::*;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int SC = 2;
    localparam int WL = 8;
    localparam int EW = 4;
    localparam int EL = 0;

    typedef struct {
        int errs[NS];
        int vmode;      // 0: valid always, 1: valid every other cycle, 2: random
        int exp_set;
        int exp_best;
        int exp_fail;
        int exp_done;   // cycle of done after the start edge, -1 = from timeline
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    eq_setting_sweep_ctrl_if #(.SET_W(SW), .ERR_W(EW)) bus ();

    eq_setting_sweep_ctrl #(
        .NUM_SETTINGS  (NS),
        .SET_W         (SW),
        .SETTLE_CYCLES (SC),
        .WINDOW_LEN    (WL),
        .ERR_W         (EW),
        .ERR_LIMIT     (EL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int e0, input int e1, input int e2, input int e3,
                                input int vm, input int es, input int eb, input int ef,
                                input int ed);
        vec_t v;
        v.errs[0] = e0; v.errs[1] = e1; v.errs[2] = e2; v.errs[3] = e3;
        v.vmode = vm; v.exp_set = es; v.exp_best = eb; v.exp_fail = ef; v.exp_done = ed;
        return v;
    endfunction

    // Reference: lowest error count wins, earliest setting on a tie.
    function automatic vec_t mk_model(input int e0, input int e1, input int e2, input int e3,
                                      input int vm);
        vec_t v;
        v = mk(e0, e1, e2, e3, vm, 0, 0, 0, -1);
        v.exp_best = v.errs[0];
        for (int s = 1; s < NS; s++) begin
            if (v.errs[s] < v.exp_best) begin
                v.exp_best = v.errs[s];
                v.exp_set  = s;
            end
        end
        v.exp_fail = (v.exp_best > EL) ? 1 : 0;
        return v;
    endfunction

    task automatic drive_cycle(input bit v, input bit err);
        bit ref_bit;
        ref_bit          = 1'($urandom);
        bus.sample_valid = v;
        bus.expected_bit = ref_bit;
        bus.sample_bit   = ref_bit ^ err;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk($sformatf("%s eq_setting", tag), int'(bus.eq_setting), 0);
        chk($sformatf("%s busy", tag),       int'(bus.busy),       0);
        chk($sformatf("%s locked", tag),     int'(bus.locked),     0);
        chk($sformatf("%s done", tag),       int'(bus.done),       0);
        chk($sformatf("%s fail", tag),       int'(bus.fail),       0);
    endtask

    // Called at a negedge. Drives one full sweep on the bench's own timeline.
    task automatic run_sweep(input vec_t v, input int abort_at, input int reset_at,
                             input bit start_mid, input string tag);
        int  edges, timeline, rem_err, rem_smp, mc;
        bit  vv, e;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        edges     = 0;
        timeline  = 0;
        chk($sformatf("%s start busy", tag),       int'(bus.busy),       1);
        chk($sformatf("%s start locked", tag),     int'(bus.locked),     0);
        chk($sformatf("%s start eq_setting", tag), int'(bus.eq_setting), 0);
        for (int s = 0; s < NS; s++) begin
            if (reset_at == s) begin
                chk($sformatf("%s pre-reset eq_setting", tag), int'(bus.eq_setting), s);
                #2 rst_n = 1'b0;
                #1;
                check_idle($sformatf("%s async reset", tag));
                chk($sformatf("%s async reset best_err", tag), int'(bus.best_err), 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            for (int c = 0; c < SC; c++) begin
                bus.start = (start_mid && s == 1 && c == 0);
                drive_cycle(1'($urandom), 1'($urandom));
                bus.start = 1'b0;
                edges++;
            end
            chk($sformatf("%s measure eq_setting", tag), int'(bus.eq_setting), s);
            rem_err = v.errs[s];
            rem_smp = WL;
            mc      = 0;
            while (rem_smp > 0) begin
                if (abort_at == s && (WL - rem_smp) == 3) begin
                    bus.abort = 1'b1;
                    drive_cycle(1'b1, 1'b1);
                    bus.abort = 1'b0;
                    check_idle($sformatf("%s abort", tag));
                    drive_cycle(1'b0, 1'b0);
                    drive_cycle(1'b1, 1'b0);
                    chk($sformatf("%s abort stays idle", tag), int'(bus.busy), 0);
                    return;
                end
                case (v.vmode)
                    0:       vv = 1'b1;
                    1:       vv = (mc % 2 == 1);
                    default: vv = 1'($urandom);
                endcase
                if (vv) begin
                    e = (int'($urandom_range(rem_smp - 1, 0)) < rem_err);
                    if (e) rem_err--;
                    rem_smp--;
                end else begin
                    e = 1'($urandom);
                end
                drive_cycle(vv, e);
                mc++;
                edges++;
            end
            drive_cycle(1'($urandom), 1'($urandom));
            edges++;
            timeline += SC + mc + 1;
        end
        for (int k = 0; k < 8 && bus.done !== 1'b1; k++) begin
            drive_cycle(1'b0, 1'b0);
            edges++;
        end
        chk($sformatf("%s done seen", tag), int'(bus.done), 1);
        chk($sformatf("%s done cycle", tag), edges + 1,
            (v.exp_done >= 0) ? v.exp_done : timeline + 2);
        chk($sformatf("%s eq_setting", tag), int'(bus.eq_setting), v.exp_set);
        chk($sformatf("%s best_err", tag),   int'(bus.best_err),   v.exp_best);
        chk($sformatf("%s fail", tag),       int'(bus.fail),       v.exp_fail);
        chk($sformatf("%s locked", tag),     int'(bus.locked),     1);
        chk($sformatf("%s busy", tag),       int'(bus.busy),       0);
        drive_cycle(1'b1, 1'b1);
        chk($sformatf("%s done pulse", tag),  int'(bus.done),       0);
        chk($sformatf("%s hold locked", tag), int'(bus.locked),     1);
        chk($sformatf("%s hold setting", tag), int'(bus.eq_setting), v.exp_set);
    endtask

    initial begin
        vec_t tbl[$];
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_bit   = 1'b0;
        bus.expected_bit = 1'b0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset best_err", int'(bus.best_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        tbl.push_back(mk(5, 1, 3, 1, 0, 1, 1, 1, 46));
        tbl.push_back(mk(4, 6, 2, 0, 0, 3, 0, 0, 46));
        tbl.push_back(mk(5, 1, 3, 1, 1, 1, 1, 1, 78));
        tbl.push_back(mk(8, 8, 8, 8, 0, 0, 8, 1, 46));
        tbl.push_back(mk(0, 0, 5, 7, 0, 0, 0, 0, 46));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk_model(int'($urandom_range(WL, 0)), int'($urandom_range(WL, 0)),
                                   int'($urandom_range(WL, 0)), int'($urandom_range(WL, 0)), 2));
        for (int i = 0; i < tbl.size(); i++)
            run_sweep(tbl[i], -1, -1, 1'b0, $sformatf("vec%0d", i));

        run_sweep(mk(5, 1, 3, 1, 0, 1, 1, 1, 46), -1, -1, 1'b1, "start_mid");
        run_sweep(mk(4, 6, 2, 0, 0, 3, 0, 0, 46), -1, -1, 1'b0, "restart_locked");
        run_sweep(mk(5, 1, 3, 1, 0, 1, 1, 1, 46), 2, -1, 1'b0, "abort");
        run_sweep(mk(3, 7, 2, 5, 0, 2, 2, 1, 46), -1, -1, 1'b0, "after_abort");
        run_sweep(mk(5, 1, 3, 1, 0, 1, 1, 1, 46), -1, 1, 1'b0, "reset");
        run_sweep(mk(6, 2, 2, 8, 0, 1, 2, 1, 46), -1, -1, 1'b0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
